event_emitter: RTL and testbench
================================

# event_emitter

Synthetic event source for the EventFilter datapath: emits bursts of 8-bit address-event words over a valid/ready handshake, with programmable burst length, inter-event gap and address pattern. It sits on the input side of the filter, driving its event port on chip or in self-test, so the filter can be exercised without external stimulus.

## Interface
- LFSR_SEED, 8'hA5, reset value of the address LFSR; must be nonzero
- GAP_W, 8, width of the inter-event gap field and counter
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ena  in  1  design enable; when low, all state, counters and the timestamp freeze
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE
- mode  in  1  0 = counting addresses, 1 = LFSR addresses; latched at start
- cfg_burst  in  4  events per burst, 0 means 16; latched at start
- cfg_gap  in  GAP_W  idle cycles between events; latched at start
- ev_data  out  8  event word {pol, addr[3:0], ts[2:0]}
- ev_valid  out  1  ev_data holds a valid event
- ev_ready  in  1  consumer accepts ev_data
- busy  out  1  high in EMIT or GAP
- done  out  1  one-cycle pulse after the last handshake of a burst
- sent_count  out  8  handshakes since reset, wraps 255 -> 0

## Operation
- Handshake: the event transfers on a rising edge where ev_valid && ev_ready && ena. Once raised, ev_valid stays high and ev_data stays stable until transfer; ev_ready is ignored while ena is low.
- States: IDLE, EMIT, GAP.
- IDLE: on start && ena, latch mode, burst and gap. Set burst_left = cfg_burst (0 -> 16) and addr_cnt = 0. Load the first word, then go to EMIT. A start in EMIT or GAP is ignored.
- EMIT: on transfer, decrement burst_left and increment sent_count.
  - If burst_left was 1: go to IDLE and pulse done.
  - Else if gap = 0: load the next word and stay in EMIT.
  - Else: load the gap counter with gap and go to GAP.
- GAP: ev_valid = 0; the counter decrements each ena cycle. When it reaches 0, load the next word and go to EMIT.
- Word fields:
  - ts: a 3-bit free-running counter, reset to 0, incremented every ena cycle, sampled in the cycle the word is loaded.
  - Counting mode: addr = addr_cnt (increments per word, wraps 15 -> 0); pol alternates per word, starting at 0.
  - LFSR mode: addr = lfsr[3:0], pol = lfsr[7]. The LFSR is an 8-bit Fibonacci register with polynomial x^8+x^6+x^5+x^4+1. It advances once per transfer in LFSR mode only and carries across bursts; only rst reloads LFSR_SEED.
- Reset values: ev_data = 0, ev_valid = 0, busy = 0, done = 0, sent_count = 0, state IDLE, ts = 0, LFSR = LFSR_SEED. All outputs clear immediately on rst, with no clock edge required; this includes reset mid-burst.

## Timing
- Start sampled at edge N -> ev_valid high in cycle N+1 with registered ev_data.
- gap = 0 with ev_ready held high -> one event per cycle; ev_valid never drops within the burst.
- gap = G > 0 -> after a transfer at edge M, ev_valid is low for exactly G cycles and high again in cycle M+G+1.
- Last transfer at edge L -> in cycle L+1, done = 1, busy = 0 and ev_valid = 0. A new start is accepted at edge L+1 at the earliest.
- All outputs are registered; there is no combinational path from ev_ready to ev_valid.

## Configuration
- EVENT_EMITTER_ABORT_EN: adds input `abort` (1 bit).
  - In GAP: abort forces IDLE at the next edge and pulses done.
  - In EMIT: the pending word still completes its handshake; the FSM then treats it as the last word of the burst.
- Without the macro: no port and no logic; a burst always runs to completion or until rst.

## Structure
- Package event_pkg holds:
  - the state enum (IDLE, EMIT, GAP)
  - EV_W = 8 and the field positions (POL_BIT = 7, ADDR_MSB/LSB = 6/3, TS_MSB/LSB = 2/0)
  - the LFSR tap mask 8'hB8
  - the default seed
- One sub-module, event_lfsr: the 8-bit LFSR with ports seed, advance and state.

## Test plan
- Reset: assert rst asynchronously mid-clock -> ev_valid, busy, done, sent_count and ev_data read 0 before the next edge.
- Counting mode, burst = 3, gap = 0, ev_ready = 1:
  - addresses 0, 1, 2 and pols 0, 1, 0 on three consecutive cycles
  - ts increments by 1 per word
  - done pulses once; sent_count = 3
- Backpressure: hold ev_ready = 0 for 5 cycles in EMIT -> ev_data unchanged, ev_valid held high, sent_count unchanged; release -> one transfer.
- Gap = 4, burst = 2 -> ev_valid low for exactly 4 cycles between the two words; start pulsed while busy is ignored.
- LFSR mode, seed 8'hA5, burst = 0 -> 16 words whose addr/pol match the reference LFSR model; 16 full bursts bring sent_count to 0 (wrap at 256).
- With EVENT_EMITTER_ABORT_EN, abort in GAP -> IDLE and done at the next edge; abort in EMIT with ev_ready = 0 -> word held, done after its transfer.

Source files
------------

// File: rtl/event_pkg.sv
// event_pkg: state encoding, event word layout and LFSR helpers shared by the event emitter.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package event_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int EV_W     = 8;
    localparam int POL_BIT  = 7;
    localparam int ADDR_MSB = 6;
    localparam int ADDR_LSB = 3;
    localparam int TS_MSB   = 2;
    localparam int TS_LSB   = 0;

    // Taps for x^8+x^6+x^5+x^4+1 (stages 8,6,5,4 -> bits 7,5,4,3).
    localparam logic [EV_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [EV_W-1:0] DEFAULT_SEED = 8'hA5;

    // One Fibonacci step: shift towards the MSB, feedback enters at bit 0.
    function automatic logic [EV_W-1:0] lfsr_next(input logic [EV_W-1:0] s);
        return {s[EV_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [EV_W-1:0] pack_word(input logic pol, input logic [3:0] addr,
                                                  input logic [2:0] ts);
        logic [EV_W-1:0] w;
        w                    = '0;
        w[POL_BIT]           = pol;
        w[ADDR_MSB:ADDR_LSB] = addr;
        w[TS_MSB:TS_LSB]     = ts;
        return w;
    endfunction

    // LFSR-mode word: polarity from the register MSB, address from its low nibble.
    function automatic logic [EV_W-1:0] lfsr_word(input logic [EV_W-1:0] s, input logic [2:0] ts);
        return pack_word(s[EV_W-1], s[3:0], ts);
    endfunction

endpackage

// File: rtl/event_lfsr.sv
// event_lfsr: 8-bit Fibonacci LFSR feeding LFSR-mode addresses; reloads seed only on reset.
// Latency: new state visible the cycle after advance.
// Backpressure: none; advances only when the owner requests it.
module event_lfsr
    import event_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [EV_W-1:0] seed,
    input  logic            advance,
    output logic [EV_W-1:0] state
);

    // Step the register once per requested advance; state survives across bursts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/event_emitter.sv
// event_emitter: synthetic address-event burst source; optional abort input under EVENT_EMITTER_ABORT_EN.
// Latency: start sampled at edge N -> registered word with ev_valid in cycle N+1; one word/cycle at gap 0.
// Backpressure: ev_valid/ev_data hold until ev_ready && ena; no combinational path from ev_ready to outputs.
module event_emitter
    import event_pkg::*;
#(
    parameter logic [EV_W-1:0] LFSR_SEED = DEFAULT_SEED,
    parameter int              GAP_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic             mode,
    input  logic [3:0]       cfg_burst,
    input  logic [GAP_W-1:0] cfg_gap,
`ifdef EVENT_EMITTER_ABORT_EN
    input  logic             abort,
`endif
    output logic [EV_W-1:0]  ev_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             busy,
    output logic             done,
    output logic [7:0]       sent_count
);

    state_t           state, state_nxt;
    logic             xfer, last_word, abort_now;
    logic             load_first, load_next, load_gap, finish;
    logic [4:0]       burst_left;
    logic [GAP_W-1:0] gap_q, gap_cnt;
    logic             mode_q;
    logic [3:0]       addr_cnt;
    logic [2:0]       ts;
    logic [EV_W-1:0]  lfsr_state, lfsr_src, first_word, next_word;

    assign xfer = ev_valid && ev_ready && ena;

`ifdef EVENT_EMITTER_ABORT_EN
    logic abort_pend;

    // Remember an abort raised during EMIT so the word in flight closes the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_pend <= 1'b0;
        end else if (ena) begin
            if (finish || load_first) begin
                abort_pend <= 1'b0;
            end else if (abort && state == EMIT) begin
                abort_pend <= 1'b1;
            end
        end
    end

    assign last_word = (burst_left == 5'd1) || abort_pend || abort;
    assign abort_now = abort && (state == GAP);
`else
    assign last_word = (burst_left == 5'd1);
    assign abort_now = 1'b0;
`endif

    event_lfsr u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .seed    (LFSR_SEED),
        .advance (xfer && mode_q),
        .state   (lfsr_state)
    );

    // A word loaded on a transfer edge must see the LFSR value that edge produces.
    assign lfsr_src   = (state == EMIT) ? lfsr_next(lfsr_state) : lfsr_state;
    assign first_word = mode   ? lfsr_word(lfsr_src, ts) : pack_word(1'b0, 4'd0, ts);
    assign next_word  = mode_q ? lfsr_word(lfsr_src, ts) : pack_word(addr_cnt[0], addr_cnt, ts);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; nothing moves while ena is low.
    always_comb begin
        state_nxt = state;
        if (ena) begin
            case (state)
                IDLE: if (start) state_nxt = EMIT;
                EMIT: begin
                    if (xfer) begin
                        if (last_word)                  state_nxt = IDLE;
                        else if (gap_q != '0)           state_nxt = GAP;
                    end
                end
                GAP: begin
                    if (abort_now)                      state_nxt = IDLE;
                    else if (gap_cnt == GAP_W'(1))      state_nxt = EMIT;
                end
                default:                                state_nxt = IDLE;
            endcase
        end
    end

    // Datapath strobes derived from the current state and the handshake.
    always_comb begin
        load_first = 1'b0;
        load_next  = 1'b0;
        load_gap   = 1'b0;
        finish     = 1'b0;
        if (ena) begin
            case (state)
                IDLE: load_first = start;
                EMIT: begin
                    if (xfer) begin
                        if (last_word)                  finish    = 1'b1;
                        else if (gap_q == '0)           load_next = 1'b1;
                        else                            load_gap  = 1'b1;
                    end
                end
                GAP: begin
                    if (abort_now)                      finish    = 1'b1;
                    else if (gap_cnt == GAP_W'(1))      load_next = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Registered outputs, burst configuration, counters and the free-running timestamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_data    <= '0;
            ev_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sent_count <= 8'd0;
            ts         <= 3'd0;
            mode_q     <= 1'b0;
            gap_q      <= '0;
            gap_cnt    <= '0;
            burst_left <= 5'd0;
            addr_cnt   <= 4'd0;
        end else if (ena) begin
            ts       <= ts + 3'd1;
            ev_valid <= (state_nxt == EMIT);
            busy     <= (state_nxt != IDLE);
            done     <= finish;
            if (xfer) begin
                burst_left <= burst_left - 5'd1;
                sent_count <= sent_count + 8'd1;
            end
            if (load_first) begin
                mode_q     <= mode;
                gap_q      <= cfg_gap;
                burst_left <= (cfg_burst == 4'd0) ? 5'd16 : {1'b0, cfg_burst};
                addr_cnt   <= 4'd1;
                ev_data    <= first_word;
            end else if (load_next) begin
                ev_data <= next_word;
                if (!mode_q) addr_cnt <= addr_cnt + 4'd1;
            end
            if (load_gap) begin
                gap_cnt <= gap_q;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_event_emitter.sv
// tb_event_emitter: randomized bursts checked against a word-level reference of the emitter.
// Latency: expects ev_valid one cycle after start, and done one cycle after the last transfer.
// Backpressure: drives random ev_ready/ena and expects held words to stay stable.
module tb_event_emitter;

    logic       clk = 1'b0;
    logic       rst, ena, start, mode, ev_ready;
    logic [3:0] cfg_burst;
    logic [7:0] cfg_gap;
    logic [7:0] ev_data;
    logic       ev_valid, busy, done;
    logic [7:0] sent_count;
`ifdef EVENT_EMITTER_ABORT_EN
    logic       abort;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_sent;
    logic [7:0] exp_lfsr;

    always #5 clk = ~clk;

    event_emitter #(.LFSR_SEED(8'hA5), .GAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .start      (start),
        .mode       (mode),
        .cfg_burst  (cfg_burst),
        .cfg_gap    (cfg_gap),
`ifdef EVENT_EMITTER_ABORT_EN
        .abort      (abort),
`endif
        .ev_data    (ev_data),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count)
    );

    // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, new bit from stages 8,6,5,4 enters at the bottom.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[5] ^ s[4] ^ s[3];
        return {s[6:0], fb};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        exp_sent = 8'd0;
        exp_lfsr = 8'hA5;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++; if (ev_valid !== 1'b0)   begin errors++; $display("FAIL rst_valid got %h want 0", ev_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got %h want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done got %h want 0", done); end
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL rst_sent got %h want 0", sent_count); end
        checks++; if (ev_data !== 8'd0)    begin errors++; $display("FAIL rst_data got %h want 0", ev_data); end
        #19 rst = 1'b0;
        exp_sent = 8'd0;
        exp_lfsr = 8'hA5;
        tick;
        // Reset in the middle of a burst, between clock edges.
        mode = 1'b0; cfg_burst = 4'd3; cfg_gap = 8'd0; ev_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        exp_sent++;
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL pre_rst_sent got %h want %h", sent_count, exp_sent); end
        #3 rst = 1'b1;
        #1;
        checks++; if ({ev_valid, busy, done} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctl got %b want 000", {ev_valid, busy, done}); end
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL mid_rst_sent got %h want 0", sent_count); end
        checks++; if (ev_data !== 8'd0)    begin errors++; $display("FAIL mid_rst_data got %h want 0", ev_data); end
        #2 rst = 1'b0;
        exp_sent = 8'd0;
        exp_lfsr = 8'hA5;
        ev_ready = 1'b0;
        tick;
    endtask

    task automatic test_count_burst;
        logic [2:0] prev_ts;
        prev_ts = 3'd0;
        mode = 1'b0; cfg_burst = 4'd3; cfg_gap = 8'd0; ev_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ev_valid !== 1'b1)        begin errors++; $display("FAIL cnt_valid[%0d] got %h want 1", i, ev_valid); end
            checks++; if (ev_data[6:3] !== 4'(i))   begin errors++; $display("FAIL cnt_addr[%0d] got %h want %h", i, ev_data[6:3], 4'(i)); end
            checks++; if (ev_data[7] !== 1'(i % 2)) begin errors++; $display("FAIL cnt_pol[%0d] got %h want %h", i, ev_data[7], 1'(i % 2)); end
            if (i > 0) begin
                checks++; if (ev_data[2:0] !== prev_ts + 3'd1) begin errors++; $display("FAIL cnt_ts[%0d] got %h want %h", i, ev_data[2:0], prev_ts + 3'd1); end
            end
            prev_ts = ev_data[2:0];
            tick;
            exp_sent++;
        end
        checks++; if ({done, busy, ev_valid} !== 3'b100) begin errors++; $display("FAIL cnt_done got %b want 100", {done, busy, ev_valid}); end
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL cnt_sent got %h want %h", sent_count, exp_sent); end
        // Back-to-back: a start in the done cycle is accepted.
        ev_ready = 1'b0; cfg_burst = 4'd1; start = 1'b1;
        tick;
        start = 1'b0;
        checks++; if ({done, busy, ev_valid} !== 3'b011) begin errors++; $display("FAIL b2b_ctl got %b want 011", {done, busy, ev_valid}); end
        checks++; if (ev_data[7:3] !== 5'd0) begin errors++; $display("FAIL b2b_word got %h want 00", ev_data[7:3]); end
        ev_ready = 1'b1;
        tick;
        exp_sent++;
        checks++; if ({done, busy, ev_valid} !== 3'b100) begin errors++; $display("FAIL b2b_done got %b want 100", {done, busy, ev_valid}); end
        ev_ready = 1'b0;
        tick;
    endtask

    task automatic test_backpressure;
        logic [7:0] held;
        mode = 1'b0; cfg_burst = 4'd2; cfg_gap = 8'd0; ev_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        held = ev_data;
        checks++; if (ev_data[7:3] !== 5'd0) begin errors++; $display("FAIL bp_word0 got %h want 00", ev_data[7:3]); end
        for (int i = 0; i < 5; i++) begin
            tick;
            checks++; if (ev_valid !== 1'b1 || ev_data !== held) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h want 1/%h", i, ev_valid, ev_data, held); end
            checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL bp_sent[%0d] got %h want %h", i, sent_count, exp_sent); end
        end
        ev_ready = 1'b1;
        tick;
        exp_sent++;
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL bp_release got %h want %h", sent_count, exp_sent); end
        checks++; if ({ev_valid, ev_data[7:3]} !== 6'b1_1_0001) begin errors++; $display("FAIL bp_word1 got %b want 110001", {ev_valid, ev_data[7:3]}); end
        tick;
        exp_sent++;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %h want 1", done); end
        ev_ready = 1'b0;
        tick;
    endtask

    // One burst under random ready/ena; every word, gap length and ts step is checked against the model.
    task automatic run_burst(input logic m, input logic [3:0] b, input logic [7:0] g,
                             input int rdy_pct, input int ena_pct, input bit poke);
        int         n, got, budget, gap_edges, edges, last_load;
        bit         held, seen, xf;
        logic [2:0] last_ts;
        logic [7:0] held_dat;
        logic [3:0] e_addr;
        logic       e_pol;
        n = (b == 4'd0) ? 16 : int'(b);
        got = 0; budget = 4000; gap_edges = 0; edges = 0; last_load = 0;
        held = 1'b0; seen = 1'b0; last_ts = 3'd0; held_dat = 8'd0;
        mode = m; cfg_burst = b; cfg_gap = g; ena = 1'b1; ev_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        while (got < n && budget > 0) begin
            budget--;
            checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL rb_busy got %b want 10", {busy, done}); end
            if (ev_valid === 1'b1) begin
                if (!held) begin
                    if (m) begin e_addr = exp_lfsr[3:0]; e_pol = exp_lfsr[7]; end
                    else   begin e_addr = got[3:0];      e_pol = got[0];      end
                    checks++; if (ev_data[7:3] !== {e_pol, e_addr}) begin errors++; $display("FAIL rb_word[%0d] got %h want %h", got, ev_data[7:3], {e_pol, e_addr}); end
                    if (seen) begin
                        checks++; if (ev_data[2:0] !== last_ts + 3'(edges - last_load)) begin errors++; $display("FAIL rb_ts[%0d] got %h want %h", got, ev_data[2:0], last_ts + 3'(edges - last_load)); end
                    end
                    if (got > 0) begin
                        checks++; if (gap_edges !== int'(g)) begin errors++; $display("FAIL rb_gap[%0d] got %0d want %0d", got, gap_edges, g); end
                    end
                    seen = 1'b1; last_ts = ev_data[2:0]; last_load = edges; held_dat = ev_data;
                end else begin
                    checks++; if (ev_data !== held_dat) begin errors++; $display("FAIL rb_hold got %h want %h", ev_data, held_dat); end
                end
            end else begin
                checks++; if (held || got == 0) begin errors++; $display("FAIL rb_valid_drop got %h want 1", ev_valid); end
                if (poke && got > 0 && gap_edges == 1) start = 1'b1;
            end
            ena      = ($urandom_range(99) < ena_pct);
            ev_ready = ($urandom_range(99) < rdy_pct);
            xf = (ev_valid === 1'b1) && ev_ready && ena;
            if (ev_valid !== 1'b1 && ena) gap_edges++;
            if (ena) edges++;
            held = (ev_valid === 1'b1) && !xf;
            if (xf) begin
                got++;
                gap_edges = 0;
                exp_sent++;
                if (m) exp_lfsr = lfsr_step(exp_lfsr);
            end
            tick;
            start = 1'b0;
        end
        checks++; if (got != n) begin errors++; $display("FAIL rb_timeout got %0d want %0d", got, n); end
        checks++; if ({done, busy, ev_valid} !== 3'b100) begin errors++; $display("FAIL rb_done got %b want 100", {done, busy, ev_valid}); end
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL rb_sent got %h want %h", sent_count, exp_sent); end
        ena = 1'b1; ev_ready = 1'b0;
        tick;
        checks++; if ({done, busy, ev_valid} !== 3'b000) begin errors++; $display("FAIL rb_after got %b want 000", {done, busy, ev_valid}); end
    endtask

    task automatic test_gap;
        run_burst(1'b0, 4'd2, 8'd4, 100, 100, 1'b1);
        run_burst(1'b0, 4'd3, 8'd1, 100, 100, 1'b1);
    endtask

    task automatic test_lfsr;
        apply_reset;
        for (int k = 0; k < 16; k++) run_burst(1'b1, 4'd0, 8'd0, 100, 100, 1'b0);
        checks++; if (sent_count !== 8'd0) begin errors++; $display("FAIL lfsr_wrap got %h want 00", sent_count); end
    endtask

    task automatic test_random;
        for (int k = 0; k < 10; k++)
            run_burst(1'($urandom_range(1)), 4'($urandom_range(15)), 8'($urandom_range(5)), 60, 85, 1'b1);
    endtask

`ifdef EVENT_EMITTER_ABORT_EN
    task automatic test_abort;
        // Abort during GAP ends the burst at the next edge.
        mode = 1'b0; cfg_burst = 4'd4; cfg_gap = 8'd3; ev_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        exp_sent++;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        checks++; if ({done, busy, ev_valid} !== 3'b100) begin errors++; $display("FAIL abort_gap got %b want 100", {done, busy, ev_valid}); end
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL abort_gap_sent got %h want %h", sent_count, exp_sent); end
        tick;
        checks++; if ({done, busy, ev_valid} !== 3'b000) begin errors++; $display("FAIL abort_gap_after got %b want 000", {done, busy, ev_valid}); end
        // Abort during EMIT: the held word still completes, then the burst ends.
        cfg_gap = 8'd0; ev_ready = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        tick;
        checks++; if ({done, ev_valid, ev_data[7:3]} !== 7'b0_1_00000) begin errors++; $display("FAIL abort_emit_hold got %b want 0100000", {done, ev_valid, ev_data[7:3]}); end
        ev_ready = 1'b1;
        tick;
        exp_sent++;
        checks++; if ({done, busy, ev_valid} !== 3'b100) begin errors++; $display("FAIL abort_emit_done got %b want 100", {done, busy, ev_valid}); end
        checks++; if (sent_count !== exp_sent) begin errors++; $display("FAIL abort_emit_sent got %h want %h", sent_count, exp_sent); end
        ev_ready = 1'b0;
        tick;
    endtask
`endif

    initial begin
        rst = 1'b0; ena = 1'b1; start = 1'b0; mode = 1'b0;
        cfg_burst = 4'd0; cfg_gap = 8'd0; ev_ready = 1'b0;
        exp_sent = 8'd0; exp_lfsr = 8'hA5;
`ifdef EVENT_EMITTER_ABORT_EN
        abort = 1'b0;
`endif
        test_reset;
        test_count_burst;
        test_backpressure;
        test_gap;
        test_lfsr;
        test_random;
`ifdef EVENT_EMITTER_ABORT_EN
        test_abort;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
